dunit_inst_loader: RTL and testbench

Debug-unit instruction loader sitting directly upstream of the IF stage. It receives program bytes from the debug UART receiver, assembles them into 32-bit instruction words, and drives the IF stage's instruction-memory write port (`i_dunit_w_en`, `i_dunit_addr`, `i_dunit_data`). Loading stops on a halt word or when memory is full. The pipeline is held by the debug unit while `o_busy` is high.

---
 rtl/dunit_pkg.sv | 18 +
 rtl/dunit_inst_loader_word_assembler.sv | 43 ++++
 rtl/dunit_inst_loader.sv | 138 +++++++++++++
 tb/tb_dunit_inst_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dunit_pkg.sv
// Shared definitions for the debug-unit instruction loader.
package dunit_pkg;

    // Loader FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Word that terminates a load. It is still written to memory.
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    // UART bytes that make up one instruction word.
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/dunit_inst_loader_word_assembler.sv
// Big-endian byte-to-word assembler: the first byte of a word lands in the
// top byte lane. The completed word is presented combinationally with the
// 4th byte, so the parent registers it in the same cycle it is accepted.
module word_assembler
    import dunit_pkg::*;
#(
    parameter int NB_REG  = 32,
    parameter int NB_BYTE = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_byte_valid,
    input  logic [NB_BYTE-1:0] i_byte,
    output logic [NB_REG-1:0] o_word,
    output logic              o_word_valid
);

    localparam int          NB_SHIFT = NB_REG - NB_BYTE;
    localparam logic [1:0]  IDX_LAST = 2'(BYTES_PER_WORD - 1);

    logic [NB_SHIFT-1:0] shift_q;
    logic [1:0]          idx_q;

    // Word as it would look with the current byte appended.
    assign o_word       = {shift_q, i_byte};
    assign o_word_valid = i_byte_valid && (idx_q == IDX_LAST);

    // Byte index wraps 3 -> 0 on its own, so no reset is needed between words.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (i_clear) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (i_byte_valid) begin
            shift_q <= o_word[NB_SHIFT-1:0];
            idx_q   <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/dunit_inst_loader.sv
// Debug-unit instruction loader: assembles UART bytes into words and writes
// them into instruction memory from address 0 until a halt word arrives or
// memory fills up.
module dunit_inst_loader
    import dunit_pkg::*;
#(
    parameter int NB_REG   = 32,
    parameter int NB_WIDHT = 9,
    parameter int NB_BYTE  = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_valid,
    output logic                o_dunit_w_en,
    output logic [NB_WIDHT-1:0] o_dunit_addr,
    output logic [NB_REG-1:0]   o_dunit_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_full,
    output logic [NB_WIDHT-2:0] o_word_count
);

    localparam logic [NB_WIDHT-1:0] ADDR_STEP = NB_WIDHT'(BYTES_PER_WORD);
    // Byte address of the last word slot.
    localparam logic [NB_WIDHT-1:0] ADDR_LAST = ~NB_WIDHT'(BYTES_PER_WORD - 1);
    localparam logic [NB_WIDHT-2:0] CNT_ONE   = (NB_WIDHT-1)'(1);

    state_t              state_q;
    logic                w_en_q;
    logic [NB_WIDHT-1:0] addr_q;
    logic [NB_WIDHT-1:0] addr_d;
    logic [NB_REG-1:0]   data_q;
    logic                busy_q;
    logic                done_q;
    logic                full_q;
    logic [NB_WIDHT-2:0] count_q;
    logic [NB_WIDHT-2:0] count_d;

    logic                is_halt;
    logic                is_last;
    logic                write_ends;
    logic                start_acc;
    logic                byte_acc;
    logic [NB_REG-1:0]   asm_word;
    logic                asm_word_valid;

    // Write-cycle decisions and byte/start qualification.
    always_comb begin
        addr_d     = addr_q + ADDR_STEP;
        count_d    = count_q + CNT_ONE;
        is_halt    = (data_q == HALT_WORD);
        is_last    = (addr_q == ADDR_LAST);
        write_ends = (state_q == ST_WRITE) && (is_halt || is_last);
        start_acc  = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        // A byte in the write cycle starts the next word unless the load ends.
        byte_acc   = i_rx_valid &&
                     ((state_q == ST_RECV) || ((state_q == ST_WRITE) && !write_ends));
    end

    word_assembler #(
        .NB_REG  (NB_REG),
        .NB_BYTE (NB_BYTE)
    ) u_asm (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (start_acc),
        .i_byte_valid (byte_acc),
        .i_byte       (i_rx_data),
        .o_word       (asm_word),
        .o_word_valid (asm_word_valid)
    );

    // Load FSM with registered strobes, address/count and status flags.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            w_en_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            count_q <= '0;
        end else begin
            w_en_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_acc) begin
                        state_q <= ST_RECV;
                        addr_q  <= '0;
                        count_q <= '0;
                        full_q  <= 1'b0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RECV: begin
                    if (asm_word_valid) begin
                        state_q <= ST_WRITE;
                        data_q  <= asm_word;
                        w_en_q  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    addr_q  <= addr_d;
                    count_q <= count_d;
                    if (is_halt) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (is_last) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        full_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_RECV;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_dunit_w_en = w_en_q;
    assign o_dunit_addr = addr_q;
    assign o_dunit_data = data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_full       = full_q;
    assign o_word_count = count_q;

endmodule

// File: tb/tb_dunit_inst_loader.sv
// Directed bench for dunit_inst_loader: a load-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_dunit_inst_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rd = 8'h00;
    logic        rv = 1'b0;
    logic        w_en;
    logic [8:0]  addr;
    logic [31:0] data;
    logic        busy, done, full;
    logic [7:0]  cnt;

    int n_chk = 0;
    int n_fail = 0;

    logic [8:0]  wa[$];
    logic [31:0] wd[$];

    always #5 clk = ~clk;

    dunit_inst_loader dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_rx_data    (rd),
        .i_rx_valid   (rv),
        .o_dunit_w_en (w_en),
        .o_dunit_addr (addr),
        .o_dunit_data (data),
        .o_busy       (busy),
        .o_done       (done),
        .o_full       (full),
        .o_word_count (cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: a load is "active" from start until it ends; bytes build
    // a word; a completed word occupies one write cycle; then addr/count advance.
    logic        m_active = 0, m_wr = 0, m_done = 0, m_full = 0;
    logic [1:0]  m_nb = 0;
    logic [31:0] m_acc = 0, m_data = 0;
    logic [8:0]  m_addr = 0;
    logic [7:0]  m_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 0; m_wr <= 0; m_done <= 0; m_full <= 0;
            m_nb <= 0; m_acc <= 0; m_data <= 0; m_addr <= 0; m_cnt <= 0;
        end else if (m_wr) begin
            m_wr   <= 0;
            m_addr <= m_addr + 9'd4;
            m_cnt  <= m_cnt + 8'd1;
            if (m_data == 32'hFFFF_FFFF || m_addr == 9'd508) begin
                m_active <= 0;
                m_done   <= 1;
                m_full   <= (m_data != 32'hFFFF_FFFF);
            end else if (rv) begin
                m_acc <= {m_acc[23:0], rd};
                m_nb  <= 2'd1;
            end
        end else if (m_active) begin
            if (rv) begin
                m_acc <= {m_acc[23:0], rd};
                m_nb  <= m_nb + 2'd1;
                if (m_nb == 2'd3) begin
                    m_data <= {m_acc[23:0], rd};
                    m_wr   <= 1;
                end
            end
        end else if (start) begin
            m_active <= 1; m_nb <= 0; m_addr <= 0; m_cnt <= 0;
            m_done <= 0; m_full <= 0;
        end
    end

    // Per-cycle comparison against the model, and capture of every write.
    always @(negedge clk) begin
        chk("w_en",  w_en, m_wr);
        chk("addr",  addr, m_addr);
        chk("data",  data, m_data);
        chk("busy",  busy, m_active);
        chk("done",  done, m_done);
        chk("full",  full, m_full);
        chk("count", cnt,  m_cnt);
        if (w_en === 1'b1) begin
            wa.push_back(addr);
            wd.push_back(data);
        end
    end

    // One cycle of stimulus, starting and ending just after a rising edge.
    task automatic cyc(input logic s, input logic v, input logic [7:0] d);
        start = s; rv = v; rd = d;
        @(posedge clk); #1;
        start = 0; rv = 0;
    endtask

    task automatic send_word(input logic [31:0] w);
        cyc(0, 1, w[31:24]);
        cyc(0, 1, w[23:16]);
        cyc(0, 1, w[15:8]);
        cyc(0, 1, w[7:0]);
    endtask

    task automatic realign();
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt",  cnt,  0);
        chk("rst_wen",  w_en, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        realign();

        // Bytes while idle are ignored
        send_word(32'hDEAD_BEEF);
        cyc(0, 0, 0);
        chk("idle_nowrite", wa.size(), 0);
        chk("idle_busy", busy, 0);

        // Basic write
        cyc(1, 0, 0);
        send_word(32'h1234_5678);
        cyc(0, 0, 0);
        chk("basic_nwr",  wa.size(), 1);
        chk("basic_addr", wa[0], 9'd0);
        chk("basic_data", wd[0], 32'h1234_5678);
        @(negedge clk);
        chk("basic_cnt",  cnt, 1);
        chk("basic_busy", busy, 1);
        realign();

        // Start during RECV is ignored
        cyc(1, 0, 0);
        @(negedge clk);
        chk("recv_start_cnt",  cnt, 1);
        chk("recv_start_addr", addr, 9'd4);
        realign();

        // Reset mid-load
        cyc(0, 1, 8'h01);
        cyc(0, 1, 8'h02);
        rst = 1;
        #2;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_cnt",  cnt, 0);
        realign();
        rst = 0;
        wa.delete(); wd.delete();

        // Restart after reset, with a byte arriving in the write cycle
        cyc(1, 0, 0);
        send_word(32'h1122_3344);
        send_word(32'hAABB_CCDD);
        cyc(0, 0, 0);
        chk("b2b_nwr",   wa.size(), 2);
        chk("b2b_addr0", wa[0], 9'd0);
        chk("b2b_data0", wd[0], 32'h1122_3344);
        chk("b2b_addr1", wa[1], 9'd4);
        chk("b2b_data1", wd[1], 32'hAABB_CCDD);

        // Halt termination; byte in halt's write cycle and later bytes are lost
        send_word(32'hFFFF_FFFF);
        cyc(0, 1, 8'h55);
        send_word(32'h0102_0304);
        cyc(0, 0, 0);
        chk("halt_nwr",  wa.size(), 3);
        chk("halt_addr", wa[2], 9'd8);
        chk("halt_data", wd[2], 32'hFFFF_FFFF);
        @(negedge clk);
        chk("halt_done", done, 1);
        chk("halt_full", full, 0);
        chk("halt_cnt",  cnt, 3);
        chk("halt_busy", busy, 0);
        realign();

        // Start in DONE restarts at address 0
        cyc(1, 0, 0);
        @(negedge clk);
        chk("restart_done", done, 0);
        chk("restart_busy", busy, 1);
        chk("restart_cnt",  cnt, 0);
        realign();
        wa.delete(); wd.delete();

        // Fill memory with back-to-back non-halt words
        for (int i = 0; i < 128; i++) send_word(32'hA500_0000 | i);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("full_nwr",   wa.size(), 128);
        chk("full_first", wa[0], 9'd0);
        chk("full_addr",  wa[127], 9'd508);
        chk("full_data",  wd[127], 32'hA500_007F);
        @(negedge clk);
        chk("full_done", done, 1);
        chk("full_full", full, 1);
        chk("full_cnt",  cnt, 128);
        chk("full_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
